rx_pydecode: RTL and testbench

RX_PYDECODE -- requirements
Module: rx_pydecode

---
 rtl/rx_pydecode.sv | 156 +++++++++++++++
 tb/tb_rx_pydecode.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rx_pydecode.sv
// rx_pydecode: frames a received payload into header, body and CRC phases and tracks bit counts.
// Build option RXPY_LENCHK_EN: checks the ACL LENGTH field against the per-type maximum and skips oversize bodies.
module rx_pydecode (
   input  logic        clk_6M,
   input  logic        rstz,
   input  logic        rxhdr_valid,
   input  logic [3:0]  rx_pktype,
   input  logic        is_BRmode,
   input  logic        is_eSCO,
   input  logic        is_SCO,
   input  logic [9:0]  regi_esco_len,
   input  logic        rxbit_valid,
   input  logic        rxbit,
   input  logic        rx_abort,
   output logic [1:0]  pyhdr_llid,
   output logic        pyhdr_flow,
   output logic [9:0]  pyhdr_len,
   output logic [12:0] py_bitlen,
   output logic [12:0] py_bitcnt,
   output logic        py_body,
   output logic        crc_window,
   output logic        py_done,
   output logic        len_err,
   output logic [2:0]  rx_occupy_slots
);
   typedef enum logic [2:0] {IDLE, PYHDR, BODY, CRC, DONE} state_t;
   state_t      state, nxt;
   logic [15:0] hdr, hdr_full;
   logic [3:0]  sub;
   logic        hdr16, crc_en;
   logic        t_fhs, t_hv, t_esco, t_acl, t_crc, t_hdr16;
   logic [2:0]  t_slots;
   logic [12:0] t_bitlen;
   logic [9:0]  h_len;
   logic        hdr_last, body_last, crc_last, len_bad;
   logic        new_pkt, bit_in;

   assign new_pkt   = rxhdr_valid && !rx_abort;
   assign bit_in    = rxbit_valid && !rx_abort;
   assign hdr_full  = hdr | (16'(rxbit) << sub);
   assign h_len     = hdr16 ? hdr_full[12:3] : {5'd0, hdr_full[7:3]};
   assign hdr_last  = sub == (hdr16 ? 4'd15 : 4'd7);
   assign body_last = py_bitcnt == py_bitlen - 13'd1;
   assign crc_last  = sub == 4'd15;

   // classify the incoming packet type while the header strobe is present
   always_comb begin
      t_fhs    = rx_pktype == 4'h2;
      t_hv     = !is_eSCO && rx_pktype >= 4'h5 && rx_pktype <= 4'h7;
      t_esco   = is_eSCO && (rx_pktype == 4'h6 || rx_pktype == 4'h7 || rx_pktype == 4'hc || rx_pktype == 4'hd);
      t_acl    = !(rx_pktype < 4'h2 || t_fhs || t_hv || t_esco);
      t_slots  = rx_pktype >= 4'he ? 3'd5 : rx_pktype >= 4'ha ? 3'd3 : 3'd1;
      t_crc    = t_fhs || t_esco || (t_acl && rx_pktype != 4'h9);
      t_hdr16  = !(t_slots == 3'd1 && is_BRmode);
      t_bitlen = t_fhs ? 13'd144 : t_esco ? {regi_esco_len, 3'b000} : !t_hv ? 13'd0 :
                 rx_pktype == 4'h5 ? 13'd80 : rx_pktype == 4'h6 ? 13'd160 : 13'd240;
   end

`ifdef RXPY_LENCHK_EN
   logic [9:0] max_len, t_max;
   assign len_bad = h_len > max_len;
   // LENGTH ceiling per type; EDR variants reuse the BR type codes, DV is never limited
   always_comb
      case (rx_pktype)
         4'h3:    t_max = 10'd17;
         4'h4:    t_max = is_BRmode ? 10'd27 : 10'd54;
         4'h8:    t_max = is_SCO ? 10'd1023 : 10'd83;
         4'h9:    t_max = 10'd29;
         4'ha:    t_max = is_BRmode ? 10'd121 : 10'd367;
         4'hb:    t_max = is_BRmode ? 10'd183 : 10'd552;
         4'he:    t_max = is_BRmode ? 10'd224 : 10'd679;
         4'hf:    t_max = is_BRmode ? 10'd339 : 10'd1021;
         default: t_max = 10'd1023;
      endcase
   // latch the ceiling with the type and flag an oversize header when it completes
   always_ff @(posedge clk_6M or negedge rstz)
      if (!rstz) begin
         max_len <= 10'd1023;
         len_err <= 1'b0;
      end else if (new_pkt) begin
         max_len <= t_max;
         len_err <= 1'b0;
      end else if (bit_in && state == PYHDR && hdr_last)
         len_err <= len_bad;
`else
   logic unused;
   assign unused  = is_SCO;
   assign len_bad = 1'b0;
   assign len_err = 1'b0;
`endif

   // next phase; abort beats a new header, a new header beats payload bits
   always_comb begin
      nxt = state;
      if (rx_abort)
         nxt = IDLE;
      else if (rxhdr_valid)
         nxt = t_acl ? PYHDR : t_bitlen == 13'd0 ? DONE : BODY;
      else if (state == DONE)
         nxt = IDLE;
      else if (rxbit_valid && state == PYHDR && hdr_last)
         nxt = len_bad ? DONE : h_len != 10'd0 ? BODY : crc_en ? CRC : DONE;
      else if (rxbit_valid && state == BODY && body_last)
         nxt = crc_en ? CRC : DONE;
      else if (rxbit_valid && state == CRC && crc_last)
         nxt = DONE;
   end

   // phase register, registered phase flags and captured payload fields
   always_ff @(posedge clk_6M or negedge rstz)
      if (!rstz) begin
         state           <= IDLE;
         hdr             <= '0;
         sub             <= '0;
         hdr16           <= 1'b0;
         crc_en          <= 1'b0;
         pyhdr_llid      <= '0;
         pyhdr_flow      <= 1'b0;
         pyhdr_len       <= '0;
         py_bitlen       <= '0;
         py_bitcnt       <= '0;
         py_body         <= 1'b0;
         crc_window      <= 1'b0;
         py_done         <= 1'b0;
         rx_occupy_slots <= 3'd1;
      end else begin
         state      <= nxt;
         py_body    <= nxt == BODY;
         crc_window <= nxt == CRC;
         py_done    <= nxt == DONE;
         if (new_pkt) begin
            hdr             <= '0;
            sub             <= '0;
            hdr16           <= t_hdr16;
            crc_en          <= t_crc;
            pyhdr_llid      <= '0;
            pyhdr_flow      <= 1'b0;
            pyhdr_len       <= '0;
            py_bitlen       <= t_bitlen;
            py_bitcnt       <= '0;
            rx_occupy_slots <= t_slots;
         end else if (bit_in && state == PYHDR) begin
            hdr <= hdr_full;
            sub <= hdr_last ? 4'd0 : sub + 4'd1;
            if (hdr_last) begin
               pyhdr_llid <= hdr_full[1:0];
               pyhdr_flow <= hdr_full[2];
               pyhdr_len  <= h_len;
               py_bitlen  <= {h_len, 3'b000};
            end
         end else if (bit_in && state == BODY)
            py_bitcnt <= py_bitcnt == 13'h1fff ? py_bitcnt : py_bitcnt + 13'd1;
         else if (bit_in && state == CRC)
            sub <= sub + 4'd1;
      end
endmodule

// File: tb/tb_rx_pydecode.sv
// tb_rx_pydecode: directed and randomized packets against a rule-level payload model.
module tb_rx_pydecode;
   logic        clk_6M = 1'b0;
   logic        rstz = 1'b0;
   logic        rxhdr_valid = 1'b0;
   logic [3:0]  rx_pktype = '0;
   logic        is_BRmode = 1'b0, is_eSCO = 1'b0, is_SCO = 1'b0;
   logic [9:0]  regi_esco_len = '0;
   logic        rxbit_valid = 1'b0, rxbit = 1'b0, rx_abort = 1'b0;
   logic [1:0]  pyhdr_llid;
   logic        pyhdr_flow;
   logic [9:0]  pyhdr_len;
   logic [12:0] py_bitlen, py_bitcnt;
   logic        py_body, crc_window, py_done, len_err;
   logic [2:0]  rx_occupy_slots;
   int checks = 0, errors = 0;
   int e_slots, e_hdrbits, e_bitlen, e_body, e_crcbits, e_total, e_lenerr, e_len;
   bit e_acl;
   int br_max[16]  = '{1023, 1023, 1023, 17, 27, 1023, 1023, 1023, 83, 29, 121, 183, 1023, 1023, 224, 339};
   int edr_max[16] = '{1023, 1023, 1023, 17, 54, 1023, 1023, 1023, 83, 29, 367, 552, 1023, 1023, 679, 1021};
`ifdef RXPY_LENCHK_EN
   int lenchk = 1;
`else
   int lenchk = 0;
`endif

   rx_pydecode dut (
      .clk_6M(clk_6M), .rstz(rstz), .rxhdr_valid(rxhdr_valid), .rx_pktype(rx_pktype),
      .is_BRmode(is_BRmode), .is_eSCO(is_eSCO), .is_SCO(is_SCO), .regi_esco_len(regi_esco_len),
      .rxbit_valid(rxbit_valid), .rxbit(rxbit), .rx_abort(rx_abort),
      .pyhdr_llid(pyhdr_llid), .pyhdr_flow(pyhdr_flow), .pyhdr_len(pyhdr_len),
      .py_bitlen(py_bitlen), .py_bitcnt(py_bitcnt), .py_body(py_body), .crc_window(crc_window),
      .py_done(py_done), .len_err(len_err), .rx_occupy_slots(rx_occupy_slots)
   );

   always #83 clk_6M = ~clk_6M;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model(input int t, input bit br, input bit esco, input bit sco, input int elen, input int len);
      bit fhs, hv, escop, crc;
      int lim;
      fhs       = t == 2;
      hv        = !esco && t >= 5 && t <= 7;
      escop     = esco && (t == 6 || t == 7 || t == 12 || t == 13);
      e_acl     = t > 1 && !fhs && !hv && !escop;
      e_slots   = t >= 14 ? 5 : t >= 10 ? 3 : 1;
      e_hdrbits = !e_acl ? 0 : (e_slots == 1 && br) ? 8 : 16;
      e_bitlen  = fhs ? 144 : hv ? 80 * (t - 4) : escop ? elen * 8 : e_acl ? len * 8 : 0;
      crc       = fhs || escop || (e_acl && t != 9);
      lim       = (t == 8 && sco) ? 1023 : br ? br_max[t] : edr_max[t];
      e_lenerr  = (lenchk != 0 && e_acl && len > lim) ? 1 : 0;
      e_body    = e_lenerr != 0 ? 0 : e_bitlen;
      e_crcbits = (crc && e_lenerr == 0 && (e_acl || e_bitlen > 0)) ? 16 : 0;
      e_total   = e_hdrbits + e_body + e_crcbits;
      e_len     = e_acl ? len : 0;
   endtask

   task automatic reset_chk(input string tag);
      chk({tag, "_llid"}, pyhdr_llid, 0);
      chk({tag, "_flow"}, pyhdr_flow, 0);
      chk({tag, "_len"}, pyhdr_len, 0);
      chk({tag, "_bitlen"}, py_bitlen, 0);
      chk({tag, "_bitcnt"}, py_bitcnt, 0);
      chk({tag, "_body"}, py_body, 0);
      chk({tag, "_crcwin"}, crc_window, 0);
      chk({tag, "_done"}, py_done, 0);
      chk({tag, "_lenerr"}, len_err, 0);
      chk({tag, "_slots"}, rx_occupy_slots, 1);
   endtask

   task automatic run_pkt(input int t, input bit br, input bit esco, input bit sco, input int elen,
                          input int len_in, input int llid, input int flow, input int gap);
      logic [15:0] hv;
      int len, sent, since, done_at, body_seen, crc_seen;
      bit v;
      model(t, br, esco, sco, elen, len_in);
      len = e_hdrbits == 8 ? len_in % 32 : len_in % 1024;
      model(t, br, esco, sco, elen, len);
      hv = e_hdrbits == 8 ? {8'd0, 5'(len), 1'(flow), 2'(llid)} : {3'($urandom), 10'(len), 1'(flow), 2'(llid)};
      @(negedge clk_6M);
      rxhdr_valid = 1'b1; rx_pktype = 4'(t); is_BRmode = br; is_eSCO = esco; is_SCO = sco;
      regi_esco_len = 10'(elen); rxbit_valid = 1'b0;
      sent = 0; since = 0; done_at = -1; body_seen = 0; crc_seen = 0;
      for (int c = 0; c < 6000 && done_at < 0; c++) begin
         @(negedge clk_6M);
         rxhdr_valid = 1'b0; rxbit_valid = 1'b0;
         rx_pktype = 4'($urandom); is_BRmode = 1'($urandom); is_eSCO = 1'($urandom); is_SCO = 1'($urandom);
         since++;
         if (py_done) done_at = since;
         else begin
            v = $urandom_range(99) >= gap;
            rxbit_valid = v;
            rxbit = sent < e_hdrbits ? hv[sent] : 1'($urandom);
            if (v) begin
               if (py_body) body_seen++;
               if (crc_window) crc_seen++;
               sent++;
               if (sent == e_total) since = 0;
            end
         end
      end
      chk("done_delay", done_at, 1);
      chk("bits_to_done", sent, e_total);
      chk("body_bits", body_seen, e_body);
      chk("crc_bits", crc_seen, e_crcbits);
      chk("py_bitlen", py_bitlen, e_bitlen);
      chk("py_bitcnt", py_bitcnt, e_body);
      chk("pyhdr_llid", pyhdr_llid, e_acl ? llid : 0);
      chk("pyhdr_flow", pyhdr_flow, e_acl ? flow : 0);
      chk("pyhdr_len", pyhdr_len, e_len);
      chk("slots", rx_occupy_slots, e_slots);
      chk("len_err", len_err, e_lenerr);
      @(negedge clk_6M);
      chk("done_pulse", py_done, 0);
   endtask

   // multi-slot ACL packet cut short after nbits: kind 0 abort, 1 reset, 2 left for a restarting header
   task automatic partial(input int t, input int len, input int nbits, input int kind);
      logic [15:0] hv;
      bit saw;
      hv = {3'b101, 10'(len), 1'b1, 2'd3};
      saw = 0;
      @(negedge clk_6M);
      rxhdr_valid = 1'b1; rx_pktype = 4'(t); is_BRmode = 1'b1; is_eSCO = 1'b0; is_SCO = 1'b0; rxbit_valid = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk_6M);
         rxhdr_valid = 1'b0;
         if (py_done) saw = 1;
         rxbit_valid = 1'b1;
         rxbit = i < 16 ? hv[i] : 1'($urandom);
      end
      @(negedge clk_6M);
      rxbit_valid = 1'b0;
      if (py_done) saw = 1;
      if (kind == 0) begin
         rx_abort = 1'b1; rxhdr_valid = 1'b1; rx_pktype = 4'h0; rxbit_valid = 1'b1;
         @(negedge clk_6M);
         rx_abort = 1'b0; rxhdr_valid = 1'b0; rxbit_valid = 1'b0;
         chk("abort_body", py_body, 0);
         chk("abort_crcwin", crc_window, 0);
         chk("abort_len_held", pyhdr_len, len);
         chk("abort_bitlen_held", py_bitlen, len * 8);
         chk("abort_slots_held", rx_occupy_slots, t >= 14 ? 5 : 3);
      end else if (kind == 1) begin
         rstz = 1'b0;
         @(negedge clk_6M);
         reset_chk("midrst");
         rstz = 1'b1;
      end
      if (kind != 2)
         for (int i = 0; i < 4; i++) begin
            if (py_done) saw = 1;
            @(negedge clk_6M);
         end
      chk("cut_no_done", saw, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk_6M);
      reset_chk("rst");
      rstz = 1'b1;
      run_pkt(3, 1, 0, 0, 0, 10, 2, 0, 0);
      run_pkt(15, 1, 0, 0, 0, 339, 1, 1, 10);
      run_pkt(7, 1, 0, 0, 0, 0, 0, 0, 20);
      run_pkt(0, 1, 0, 0, 0, 0, 0, 0, 0);
      partial(10, 20, 50, 0);
      run_pkt(10, 1, 0, 0, 0, 7, 1, 0, 15);
      run_pkt(4, 1, 0, 0, 0, 31, 3, 1, 5);
      run_pkt(8, 1, 0, 1, 0, 200, 0, 1, 5);
      run_pkt(9, 1, 0, 0, 0, 0, 1, 1, 0);
      partial(15, 40, 30, 2);
      run_pkt(12, 0, 1, 0, 10, 0, 0, 0, 10);
      run_pkt(6, 0, 1, 0, 0, 0, 0, 0, 0);
      run_pkt(2, 0, 0, 0, 0, 0, 0, 0, 25);
      for (int n = 0; n < 30; n++)
         run_pkt($urandom_range(15), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(30),
                 $urandom_range(40), $urandom_range(3), $urandom_range(1), $urandom_range(30));
      partial(11, 30, 40, 1);
      run_pkt(3, 1, 0, 0, 0, 5, 1, 1, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
